// File: rtl/disp_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller: programmable slot rate, per-slot
// anti-ghost blanking, per-digit blink and frame-synchronous shadow-register updates.
module disp_scan_ctrl #(
    parameter int  DIGITS       = 4,
    parameter int  SCAN_DIV     = 50000,
    parameter int  BLANK_CYC    = 16,
    parameter int  BLINK_FRAMES = 64,
    localparam int SW           = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [4*DIGITS-1:0] hexs,
    input  logic [DIGITS-1:0]   points,
    input  logic [DIGITS-1:0]   les,
    input  logic                load,
    output logic [DIGITS-1:0]   an,
    output logic [7:0]          seg,
    output logic [SW-1:0]       scan,
    output logic                pending,
    output logic                frame_start
);

    localparam int SLOT_W  = $clog2(SCAN_DIV);
    localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(SCAN_DIV - 1);
    localparam logic [SLOT_W-1:0]  BLANK_END  = SLOT_W'(BLANK_CYC);
    localparam logic [SW-1:0]      DIGIT_LAST = SW'(DIGITS - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);

    // Scan and blink state
    logic [SLOT_W-1:0]  slot_q, slot_d;
    logic [SW-1:0]      digit_q, digit_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_off_q, blink_off_d;

    // Pending (written by load) and displayed (frame-synchronous) copies
    logic [4*DIGITS-1:0] pend_hex_q, pend_hex_d;
    logic [DIGITS-1:0]   pend_pt_q, pend_pt_d;
    logic [DIGITS-1:0]   pend_le_q, pend_le_d;
    logic                pending_q, pending_d;
    logic [4*DIGITS-1:0] disp_hex_q, disp_hex_d;
    logic [DIGITS-1:0]   disp_pt_q, disp_pt_d;
    logic [DIGITS-1:0]   disp_le_q, disp_le_d;

    // Registered pin drivers
    logic [DIGITS-1:0] an_q, an_d;
    logic [7:0]        seg_q, seg_d;
    logic              frame_start_q, frame_start_d;

    logic       slot_last;
    logic       digit_last;
    logic       fb;
    logic       blank;
    int         digit_idx;
    logic [3:0] cur_hex;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] r;
        case (nib)
            4'h0: r = 7'h40;
            4'h1: r = 7'h79;
            4'h2: r = 7'h24;
            4'h3: r = 7'h30;
            4'h4: r = 7'h19;
            4'h5: r = 7'h12;
            4'h6: r = 7'h02;
            4'h7: r = 7'h78;
            4'h8: r = 7'h00;
            4'h9: r = 7'h10;
            4'hA: r = 7'h08;
            4'hB: r = 7'h03;
            4'hC: r = 7'h46;
            4'hD: r = 7'h21;
            4'hE: r = 7'h06;
            default: r = 7'h0E;
        endcase
        return r;
    endfunction

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
        slot_d        = slot_q;
        digit_d       = digit_q;
        blink_cnt_d   = blink_cnt_q;
        blink_off_d   = blink_off_q;
        pend_hex_d    = pend_hex_q;
        pend_pt_d     = pend_pt_q;
        pend_le_d     = pend_le_q;
        pending_d     = pending_q;
        disp_hex_d    = disp_hex_q;
        disp_pt_d     = disp_pt_q;
        disp_le_d     = disp_le_q;

        slot_last  = (slot_q == SLOT_LAST);
        digit_last = (digit_q == DIGIT_LAST);
        fb         = en && slot_last && digit_last;

        if (en) begin
            slot_d = slot_last ? '0 : slot_q + 1'b1;
            if (slot_last) begin
                digit_d = digit_last ? '0 : digit_q + 1'b1;
            end
        end

        if (fb) begin
            blink_cnt_d = (blink_cnt_q == BLINK_LAST) ? '0 : blink_cnt_q + 1'b1;
            if (blink_cnt_q == BLINK_LAST) begin
                blink_off_d = ~blink_off_q;
            end
            // The shadow copy moves first, so a load in this very cycle waits one more frame.
            if (pending_q) begin
                disp_hex_d = pend_hex_q;
                disp_pt_d  = pend_pt_q;
                disp_le_d  = pend_le_q;
            end
        end

        if (load) begin
            pend_hex_d = hexs;
            pend_pt_d  = points;
            pend_le_d  = les;
            pending_d  = 1'b1;
        end else if (fb) begin
            pending_d = 1'b0;
        end

        digit_idx = int'(digit_q);
        cur_hex   = disp_hex_q[4*digit_idx +: 4];
        blank     = !en || (slot_q < BLANK_END) || (disp_le_q[digit_idx] && blink_off_q);

        an_d          = blank ? '1 : ~(DIGITS'(1) << digit_q);
        seg_d         = blank ? 8'hFF : {~disp_pt_q[digit_idx], hex_to_seg(cur_hex)};
        frame_start_d = fb;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q        <= '0;
            digit_q       <= '0;
            blink_cnt_q   <= '0;
            blink_off_q   <= 1'b0;
            pend_hex_q    <= '0;
            pend_pt_q     <= '0;
            pend_le_q     <= '0;
            pending_q     <= 1'b0;
            disp_hex_q    <= '0;
            disp_pt_q     <= '0;
            disp_le_q     <= '0;
            an_q          <= '1;
            seg_q         <= 8'hFF;
            frame_start_q <= 1'b0;
        end else begin
            slot_q        <= slot_d;
            digit_q       <= digit_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_off_q   <= blink_off_d;
            pend_hex_q    <= pend_hex_d;
            pend_pt_q     <= pend_pt_d;
            pend_le_q     <= pend_le_d;
            pending_q     <= pending_d;
            disp_hex_q    <= disp_hex_d;
            disp_pt_q     <= disp_pt_d;
            disp_le_q     <= disp_le_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign an          = an_q;
    assign seg         = seg_q;
    assign scan        = digit_q;
    assign pending     = pending_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Directed bench for disp_scan_ctrl with DIGITS=4, SCAN_DIV=8, BLANK_CYC=2, BLINK_FRAMES=2
// (one frame = 32 cycles); each frame is checked cycle by cycle.
module tb_disp_scan_ctrl;

    logic        clk;
    logic        rst;
    logic        en;
    logic [15:0] hexs;
    logic [3:0]  points;
    logic [3:0]  les;
    logic        load;
    logic [3:0]  an;
    logic [7:0]  seg;
    logic [1:0]  scan;
    logic        pending;
    logic        frame_start;

    int   n_checks;
    int   n_fail;
    int   frame_no;
    logic exp_pending;

    disp_scan_ctrl #(
        .DIGITS      (4),
        .SCAN_DIV    (8),
        .BLANK_CYC   (2),
        .BLINK_FRAMES(2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .hexs       (hexs),
        .points     (points),
        .les        (les),
        .load       (load),
        .an         (an),
        .seg        (seg),
        .scan       (scan),
        .pending    (pending),
        .frame_start(frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] seg_ref(input logic [3:0] nib);
        logic [6:0] t [16];
        t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return t[nib];
    endfunction

    // Runs one frame from state (digit 0, slot 0). shown_* is what the frame must
    // display, dark marks digits in their blink-off phase; loads happen at ticks ld1/ld2.
    task automatic run_frame(input logic [15:0] shown_hex, input logic [3:0] shown_pt,
                             input logic [3:0] dark,
                             input int ld1, input logic [15:0] hex1,
                             input int ld2, input logic [15:0] hex2);
        int         p;
        int         s;
        int         d;
        logic [3:0] ea;
        logic [7:0] es;
        for (int k = 1; k <= 32; k++) begin
            load = (k == ld1) || (k == ld2);
            if (k == ld1) hexs = hex1;
            else if (k == ld2) hexs = hex2;
            if (load) exp_pending = 1'b1;
            else if (k == 32) exp_pending = 1'b0;
            tick();
            load = 1'b0;
            p = k - 1;
            s = p % 8;
            d = p / 8;
            if (s < 2 || dark[d]) begin
                ea = 4'hF;
                es = 8'hFF;
            end else begin
                ea = ~(4'b0001 << d);
                es = {~shown_pt[d], seg_ref(shown_hex[4*d +: 4])};
            end
            check($sformatf("f%0d k%0d an", frame_no, k), 32'(an), 32'(ea));
            check($sformatf("f%0d k%0d seg", frame_no, k), 32'(seg), 32'(es));
            check($sformatf("f%0d k%0d scan", frame_no, k), 32'(scan), 32'((k % 32) / 8));
            check($sformatf("f%0d k%0d frame_start", frame_no, k), 32'(frame_start), 32'(k == 32));
            check($sformatf("f%0d k%0d pending", frame_no, k), 32'(pending), 32'(exp_pending));
        end
        frame_no++;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " an"}, 32'(an), 32'h0000_000F);
        check({tag, " seg"}, 32'(seg), 32'h0000_00FF);
        check({tag, " scan"}, 32'(scan), 32'h0);
        check({tag, " pending"}, 32'(pending), 32'h0);
        check({tag, " frame_start"}, 32'(frame_start), 32'h0);
    endtask

    initial begin
        logic [3:0]  nib;
        logic [15:0] shown;
        logic [3:0]  shown_pt;
        n_checks    = 0;
        n_fail      = 0;
        frame_no    = 0;
        exp_pending = 1'b0;
        rst    = 1'b1;
        en     = 1'b0;
        load   = 1'b0;
        hexs   = '0;
        points = '0;
        les    = '0;
        repeat (3) tick();
        check_reset_outputs("reset");

        // Basic display: frame 0 shows reset contents, frame 1 shows 3A0F with dp on digit 2
        rst    = 1'b0;
        en     = 1'b1;
        points = 4'b0100;
        run_frame(16'h0000, 4'h0, 4'h0, 1, 16'h3A0F, -1, 16'h0);
        points = 4'b0000;
        // Two mid-frame loads; the last one wins, nothing changes mid-frame
        run_frame(16'h3A0F, 4'b0100, 4'h0, 10, 16'h1111, 13, 16'h2222);
        // AAAA loaded mid-frame, 5555 loaded in the FB cycle itself
        run_frame(16'h2222, 4'h0, 4'h0, 5, 16'hAAAA, 32, 16'h5555);
        run_frame(16'hAAAA, 4'h0, 4'h0, -1, 16'h0, -1, 16'h0);
        // Blink on digit 1: blink_off is set in frames 2,3,6,7,...
        points = 4'b0010;
        les    = 4'b0010;
        run_frame(16'h5555, 4'h0, 4'h0, 3, 16'h4C27, -1, 16'h0);
        run_frame(16'h4C27, 4'b0010, 4'h0, -1, 16'h0, -1, 16'h0);
        run_frame(16'h4C27, 4'b0010, 4'b0010, -1, 16'h0, -1, 16'h0);
        run_frame(16'h4C27, 4'b0010, 4'b0010, -1, 16'h0, -1, 16'h0);
        run_frame(16'h4C27, 4'b0010, 4'h0, -1, 16'h0, -1, 16'h0);
        les = 4'b0000;

        // Decode sweep: nibble n on all digits, dp pattern = n
        for (int n = 0; n <= 16; n++) begin
            if (n == 0) begin
                shown    = 16'h4C27;
                shown_pt = 4'b0010;
            end else begin
                nib      = 4'(n - 1);
                shown    = {nib, nib, nib, nib};
                shown_pt = nib;
            end
            nib    = 4'(n);
            points = nib;
            if (n < 16) run_frame(shown, shown_pt, 4'h0, 1, {nib, nib, nib, nib}, -1, 16'h0);
            else        run_frame(shown, shown_pt, 4'h0, -1, 16'h0, -1, 16'h0);
        end

        // Freeze mid-slot (digit 1, slot 3) for 20 cycles
        repeat (11) tick();
        check("pre-freeze scan", 32'(scan), 32'h1);
        en = 1'b0;
        tick();
        check("freeze an", 32'(an), 32'h0000_000F);
        check("freeze seg", 32'(seg), 32'h0000_00FF);
        check("freeze scan", 32'(scan), 32'h1);
        repeat (19) begin
            tick();
            check("hold an", 32'(an), 32'h0000_000F);
            check("hold scan", 32'(scan), 32'h1);
            check("hold frame_start", 32'(frame_start), 32'h0);
        end
        en = 1'b1;
        for (int j = 1; j <= 6; j++) begin
            tick();
            check($sformatf("resume j%0d an", j), 32'(an), (j <= 5) ? 32'h0000_000D : 32'h0000_000F);
            check($sformatf("resume j%0d seg", j), 32'(seg), (j <= 5) ? 32'h0000_000E : 32'h0000_00FF);
            check($sformatf("resume j%0d scan", j), 32'(scan), (j < 5) ? 32'h1 : 32'h2);
        end

        // Reset mid-frame with a load pending
        load = 1'b1;
        hexs = 16'h1234;
        tick();
        load = 1'b0;
        check("pre-reset pending", 32'(pending), 32'h1);
        rst = 1'b1;
        tick();
        check_reset_outputs("mid reset");
        rst         = 1'b0;
        exp_pending = 1'b0;
        run_frame(16'h0000, 4'h0, 4'h0, -1, 16'h0, -1, 16'h0);
        run_frame(16'h0000, 4'h0, 4'h0, -1, 16'h0, -1, 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
